// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: load/store type codes
// and the transaction state machine states.
package lsu_pkg;

  // Load type codes as presented on mem_load_type_mem.
  localparam logic [2:0] LT_LB   = 3'b000;
  localparam logic [2:0] LT_LH   = 3'b001;
  localparam logic [2:0] LT_LW   = 3'b010;
  localparam logic [2:0] LT_LBU  = 3'b011;
  localparam logic [2:0] LT_LHU  = 3'b100;
  localparam logic [2:0] LT_NONE = 3'b111;

  // Store type codes as presented on mem_store_type_mem.
  localparam logic [1:0] ST_SB   = 2'b00;
  localparam logic [1:0] ST_SH   = 2'b01;
  localparam logic [1:0] ST_SW   = 2'b10;
  localparam logic [1:0] ST_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REQ      = 2'b01,
    WAIT_RSP = 2'b10
  } lsu_state_e;

  // Codes above LT_LHU (101, 110, 111) carry no load.
  function automatic logic load_type_valid(input logic [2:0] lt);
    return (lt <= LT_LHU);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half/word out of the bus
// read word and sign- or zero-extends it according to the load type.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  load_type_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_byte_lane
    assign byte_lane[gi] = rdata_i[8*gi +: 8];
  end
  for (gi = 0; gi < 2; gi++) begin : g_half_lane
    assign half_lane[gi] = rdata_i[16*gi +: 16];
  end

  assign byte_sel = byte_lane[addr_lo_i];
  assign half_sel = half_lane[addr_lo_i[1]];

  // Extend the selected lane; unknown codes return zero.
  always_comb begin
    data_o = 32'h0;
    case (load_type_i)
      LT_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      LT_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      LT_LW:   data_o = rdata_i;
      LT_LBU:  data_o = {24'h0, byte_sel};
      LT_LHU:  data_o = {16'h0, half_sel};
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit. Issues one req/gnt/rvalid bus transaction per
// aligned load or store, stalls the pipeline while it is in flight, and
// reports misalignment and response timeouts as one-cycle pulses.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] rs2_data_mem,
  input  logic        mem_read_mem,
  input  logic        mem_write_mem,
  input  logic [2:0]  mem_load_type_mem,
  input  logic [1:0]  mem_store_type_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        load_done,
  output logic        misaligned,
  output logic        bus_err
);

  // Counter value on the last cycle a transaction may remain outstanding.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       ltype_q, ltype_d;
  logic [1:0]       alo_q, alo_d;

  logic             st_valid, ld_valid, acc_valid, acc_mis, timeout;
  logic [3:0]       acc_be;
  logic [31:0]      st_wdata;
  logic [31:0]      align_data;

  // Decode the incoming instruction: validity, lane enables, replicated
  // store data and alignment. A store always wins over a simultaneous read.
  always_comb begin
    st_valid = mem_write_mem && (mem_store_type_mem != ST_NONE);
    ld_valid = !mem_write_mem && mem_read_mem && load_type_valid(mem_load_type_mem);
    acc_valid = st_valid || ld_valid;
    acc_mis  = 1'b0;
    acc_be   = 4'b1111;
    st_wdata = rs2_data_mem;
    if (st_valid) begin
      case (mem_store_type_mem)
        ST_SB: begin
          acc_be   = 4'b0001 << alu_result_mem[1:0];
          st_wdata = {4{rs2_data_mem[7:0]}};
        end
        ST_SH: begin
          acc_be   = alu_result_mem[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{rs2_data_mem[15:0]}};
          acc_mis  = alu_result_mem[0];
        end
        default: acc_mis = |alu_result_mem[1:0];
      endcase
    end else if (ld_valid) begin
      case (mem_load_type_mem)
        LT_LB, LT_LBU: acc_be = 4'b0001 << alu_result_mem[1:0];
        LT_LH, LT_LHU: begin
          acc_be  = alu_result_mem[1] ? 4'b1100 : 4'b0011;
          acc_mis = alu_result_mem[0];
        end
        default: acc_mis = |alu_result_mem[1:0];
      endcase
    end
  end

  assign timeout = (cnt_q == CNT_LAST);

  // Next-state, issue capture and per-cycle handshake/stall outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    ltype_d    = ltype_q;
    alo_d      = alo_q;
    dmem_req   = 1'b0;
    mem_stall  = 1'b0;
    load_done  = 1'b0;
    misaligned = 1'b0;
    bus_err    = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (acc_valid) begin
            if (acc_mis) begin
              misaligned = 1'b1;
            end else begin
              mem_stall = 1'b1;
              state_d   = REQ;
              cnt_d     = '0;
              addr_d    = {alu_result_mem[31:2], 2'b00};
              we_d      = st_valid;
              be_d      = acc_be;
              wdata_d   = st_wdata;
              ltype_d   = st_valid ? LT_NONE : mem_load_type_mem;
              alo_d     = alu_result_mem[1:0];
            end
          end
        end
        REQ: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (timeout) begin
            bus_err = 1'b1;
            state_d = IDLE;
          end else begin
            dmem_req = 1'b1;
            if (dmem_gnt && we_q) begin
              state_d = IDLE;
            end else if (dmem_gnt) begin
              mem_stall = 1'b1;
              state_d   = WAIT_RSP;
            end else begin
              mem_stall = 1'b1;
            end
          end
        end
        WAIT_RSP: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (timeout) begin
            bus_err = 1'b1;
            state_d = IDLE;
          end else if (dmem_rvalid) begin
            load_done = 1'b1;
            state_d   = IDLE;
          end else begin
            mem_stall = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, timeout counter and issued-transaction attributes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      ltype_q <= LT_NONE;
      alo_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ltype_q <= ltype_d;
      alo_q   <= alo_d;
    end
  end

  lsu_load_align u_load_align (
    .rdata_i     (dmem_rdata),
    .addr_lo_i   (alo_q),
    .load_type_i (ltype_q),
    .data_o      (align_data)
  );

  assign dmem_addr  = addr_q;
  assign dmem_we    = we_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign load_data  = load_done ? align_data : 32'h0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: directed scenarios plus a randomized stream
// of back-to-back loads/stores checked against a size/offset reference model.
module tb_mem_stage_lsu;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_mem, rs2_data_mem;
  logic        mem_read_mem, mem_write_mem;
  logic [2:0]  mem_load_type_mem;
  logic [1:0]  mem_store_type_mem;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, load_done, misaligned, bus_err;
  logic [31:0] load_data;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .alu_result_mem(alu_result_mem), .rs2_data_mem(rs2_data_mem),
    .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem),
    .mem_load_type_mem(mem_load_type_mem), .mem_store_type_mem(mem_store_type_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .load_data(load_data), .load_done(load_done), .misaligned(misaligned),
    .bus_err(bus_err)
  );

  int nvec = 0;
  int nerr = 0;

  // Observations gathered by run_txn for the most recent instruction.
  int          o_stall, o_req, o_done, o_mis, o_err;
  logic [31:0] o_addr, o_wdata, o_ldata;
  logic [3:0]  o_be;
  logic        o_we, o_hung;

  task automatic set_idle();
    mem_write_mem      = 1'b0;
    mem_read_mem       = 1'b0;
    mem_load_type_mem  = 3'b111;
    mem_store_type_mem = 2'b11;
    alu_result_mem     = $urandom;
    rs2_data_mem       = $urandom;
    dmem_gnt           = 1'b0;
    dmem_rvalid        = 1'b0;
  endtask

  // Present one instruction and act as the memory: grant after gdly request
  // cycles, return data after rdly wait cycles. Runs until mem_stall drops.
  task automatic run_txn(input logic wr, input logic rd, input logic [2:0] lt,
                         input logic [1:0] stp, input logic [31:0] addr,
                         input logic [31:0] data, input int gdly, input int rdly,
                         input logic [31:0] rdata, input logic noise);
    int   req_seen = 0;
    int   wait_seen = 0;
    logic in_wait = 1'b0;
    logic captured = 1'b0;
    o_stall = 0; o_req = 0; o_done = 0; o_mis = 0; o_err = 0;
    o_addr = 0; o_wdata = 0; o_ldata = 0; o_be = 0; o_we = 0; o_hung = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 0) begin
        mem_write_mem = wr; mem_read_mem = rd;
        mem_load_type_mem = lt; mem_store_type_mem = stp;
        alu_result_mem = addr; rs2_data_mem = data;
      end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      #1;
      if (dmem_req) begin
        if (req_seen == gdly) dmem_gnt = 1'b1;
        req_seen++;
        if (noise && ($urandom_range(0, 1) == 1)) dmem_rvalid = 1'b1;
      end else if (in_wait) begin
        if (wait_seen == rdly) begin dmem_rvalid = 1'b1; dmem_rdata = rdata; end
        wait_seen++;
      end
      @(negedge clk);
      if (mem_stall) o_stall++;
      if (dmem_req) begin
        o_req++;
        if (!captured) begin
          captured = 1'b1;
          o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata; o_we = dmem_we;
        end
      end
      if (load_done) begin o_done++; o_ldata = load_data; end
      if (misaligned) o_mis++;
      if (bus_err) o_err++;
      if (dmem_req && dmem_gnt && !dmem_we) in_wait = 1'b1;
      if (!mem_stall) begin o_hung = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nvec++;
    if ({dmem_req, dmem_we, dmem_be, mem_stall, load_done, misaligned, bus_err} !== 10'h0) begin
      nerr++;
      $display("FAIL reset_ctrl: req/we/be/stall/done/mis/err got %b required 0",
               {dmem_req, dmem_we, dmem_be, mem_stall, load_done, misaligned, bus_err});
    end
    nvec++;
    if ({dmem_addr, dmem_wdata, load_data} !== 96'h0) begin
      nerr++;
      $display("FAIL reset_data: addr %h wdata %h load_data %h required all 0",
               dmem_addr, dmem_wdata, load_data);
    end
    rst = 1'b0;
    @(negedge clk);
    nvec++;
    if ({dmem_req, mem_stall} !== 2'b00) begin
      nerr++;
      $display("FAIL reset_release: req/stall got %b required 00", {dmem_req, mem_stall});
    end
  endtask

  task automatic test_store_lanes();
    run_txn(1'b1, 1'b0, 3'b111, 2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0);
    $display("txn SW 0x100: addr %h be %b wdata %h stall %0d", o_addr, o_be, o_wdata, o_stall);
    nvec++;
    if ({o_addr, o_be, o_wdata, o_we} !== {32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 1'b1}) begin
      nerr++;
      $display("FAIL sw_attr: addr %h be %b wdata %h we %b required 00000100 1111 deadbeef 1",
               o_addr, o_be, o_wdata, o_we);
    end
    nvec++;
    if (o_stall !== 1 || o_hung !== 1'b0) begin
      nerr++; $display("FAIL sw_stall: stall cycles %0d hung %b required 1 0", o_stall, o_hung);
    end
    run_txn(1'b1, 1'b0, 3'b111, 2'b00, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'h0, 1'b0);
    $display("txn SB 0x103: be %b wdata %h", o_be, o_wdata);
    nvec++;
    if ({o_be, o_wdata} !== {4'b1000, 32'hA5A5_A5A5}) begin
      nerr++; $display("FAIL sb_lane: be %b wdata %h required 1000 a5a5a5a5", o_be, o_wdata);
    end
    run_txn(1'b1, 1'b0, 3'b111, 2'b01, 32'h0000_0102, 32'h0000_00A5, 2, 0, 32'h0, 1'b0);
    $display("txn SH 0x102: be %b wdata %h stall %0d", o_be, o_wdata, o_stall);
    nvec++;
    if ({o_be, o_wdata} !== {4'b1100, 32'h00A5_00A5} || o_stall !== 3) begin
      nerr++;
      $display("FAIL sh_lane: be %b wdata %h stall %0d required 1100 00a500a5 3",
               o_be, o_wdata, o_stall);
    end
  endtask

  task automatic test_load_extract();
    run_txn(1'b0, 1'b1, 3'b000, 2'b11, 32'h0000_0201, 32'h0, 0, 2, 32'h0000_80FF, 1'b0);
    $display("txn LB 0x201: load_data %h done %0d stall %0d", o_ldata, o_done, o_stall);
    nvec++;
    if (o_ldata !== 32'hFFFF_FF80 || o_done !== 1) begin
      nerr++; $display("FAIL lb_ext: data %h done %0d required ffffff80 1", o_ldata, o_done);
    end
    nvec++;
    if (o_stall !== 4 || o_addr !== 32'h0000_0200) begin
      nerr++; $display("FAIL lb_timing: stall %0d addr %h required 4 00000200", o_stall, o_addr);
    end
    run_txn(1'b0, 1'b1, 3'b011, 2'b11, 32'h0000_0201, 32'h0, 0, 0, 32'h0000_80FF, 1'b0);
    $display("txn LBU 0x201: load_data %h stall %0d", o_ldata, o_stall);
    nvec++;
    if (o_ldata !== 32'h0000_0080 || o_stall !== 2) begin
      nerr++; $display("FAIL lbu_ext: data %h stall %0d required 00000080 2", o_ldata, o_stall);
    end
    run_txn(1'b0, 1'b1, 3'b100, 2'b11, 32'h0000_0202, 32'h0, 1, 1, 32'h8001_0000, 1'b0);
    $display("txn LHU 0x202: load_data %h", o_ldata);
    nvec++;
    if (o_ldata !== 32'h0000_8001 || o_done !== 1) begin
      nerr++; $display("FAIL lhu_ext: data %h done %0d required 00008001 1", o_ldata, o_done);
    end
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 1'b1, 3'b010, 2'b11, 32'h0000_0102, 32'h0, 0, 0, 32'h0, 1'b0);
    $display("txn LW 0x102: misaligned %0d req %0d stall %0d", o_mis, o_req, o_stall);
    nvec++;
    if (o_mis !== 1 || o_req !== 0 || o_stall !== 0) begin
      nerr++;
      $display("FAIL lw_misaligned: mis %0d req %0d stall %0d required 1 0 0", o_mis, o_req, o_stall);
    end
    @(posedge clk); #1; set_idle();
    @(negedge clk);
    nvec++;
    if ({dmem_req, misaligned, mem_stall} !== 3'b000) begin
      nerr++;
      $display("FAIL mis_after: req/mis/stall got %b required 000", {dmem_req, misaligned, mem_stall});
    end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 1'b1, 3'b010, 2'b11, 32'h0000_0300, 32'h0, 0, 100000, 32'h0, 1'b0);
    $display("txn LW 0x300 no rvalid: bus_err %0d stall %0d done %0d", o_err, o_stall, o_done);
    nvec++;
    if (o_err !== 1 || o_done !== 0 || o_hung !== 1'b0) begin
      nerr++;
      $display("FAIL timeout_err: bus_err %0d done %0d hung %b required 1 0 0", o_err, o_done, o_hung);
    end
    nvec++;
    if (o_stall !== TO) begin
      nerr++; $display("FAIL timeout_len: stall cycles %0d required %0d", o_stall, TO);
    end
    @(posedge clk); #1; set_idle(); dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    nvec++;
    if ({load_done, bus_err, mem_stall} !== 3'b000) begin
      nerr++;
      $display("FAIL late_rvalid: done/err/stall got %b required 000", {load_done, bus_err, mem_stall});
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1; set_idle();
    mem_read_mem = 1'b1; mem_load_type_mem = 3'b010; alu_result_mem = 32'h0000_0400;
    @(posedge clk); #1; dmem_gnt = 1'b1;
    @(posedge clk); #1; dmem_gnt = 1'b0;
    @(negedge clk);
    nvec++;
    if (mem_stall !== 1'b1) begin
      nerr++; $display("FAIL wait_stall: stall %b required 1", mem_stall);
    end
    #1; rst = 1'b1; #1;
    nvec++;
    if ({dmem_req, mem_stall} !== 2'b00) begin
      nerr++; $display("FAIL rst_mid: req/stall got %b required 00", {dmem_req, mem_stall});
    end
    @(negedge clk); set_idle(); rst = 1'b0;
    @(posedge clk); #1; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    $display("txn reset in WAIT_RSP: load_done after %b", load_done);
    nvec++;
    if ({load_done, mem_stall, dmem_req} !== 3'b000) begin
      nerr++;
      $display("FAIL rst_rvalid: done/stall/req got %b required 000", {load_done, mem_stall, dmem_req});
    end
    @(posedge clk); #1; set_idle();
  endtask

  function automatic int acc_size(input logic wr, input logic rd, input logic [2:0] lt,
                                  input logic [1:0] st);
    if (wr) return (st == 2'd0) ? 1 : (st == 2'd1) ? 2 : (st == 2'd2) ? 4 : 0;
    if (!rd) return 0;
    case (lt)
      3'd0, 3'd3: return 1;
      3'd1, 3'd4: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      logic        wr, rd, noise, mis, sgn;
      logic [2:0]  lt;
      logic [1:0]  stp;
      logic [31:0] addr, data, rdata, mask, exp_ld, exp_wd;
      logic [3:0]  exp_be;
      int          size, off, g, r, exp_stall, exp_req;
      wr    = ($urandom_range(0, 2) == 0);
      rd    = ($urandom_range(0, 5) != 0);
      lt    = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      stp   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr  = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      data  = $urandom; rdata = $urandom;
      g     = $urandom_range(0, 4); r = $urandom_range(0, 4);
      noise = 1'b1;
      size  = acc_size(wr, rd, lt, stp);
      off   = int'(addr[1:0]);
      mis   = (size != 0) && ((off % size) != 0);
      exp_be = 4'(((1 << size) - 1) << off);
      mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      exp_wd = (size == 1) ? (data & 32'hFF) * 32'h0101_0101 :
               (size == 2) ? (data & 32'hFFFF) * 32'h0001_0001 : data;
      exp_ld = (rdata >> (8 * off)) & mask;
      sgn   = (lt == 3'd0 || lt == 3'd1);
      if (sgn && size != 0 && size != 4 && exp_ld[8*size-1]) exp_ld = exp_ld | ~mask;
      if (size == 0 || mis) begin exp_stall = 0; exp_req = 0; end
      else if (wr)          begin exp_stall = 1 + g; exp_req = g + 1; end
      else                  begin exp_stall = 2 + g + r; exp_req = g + 1; end
      run_txn(wr, rd, lt, stp, addr, data, g, r, rdata, noise);
      $display("txn %0d: wr %b rd %b lt %0d st %0d addr %h g %0d r %0d stall %0d done %0d mis %0d",
               n, wr, rd, lt, stp, addr, g, r, o_stall, o_done, o_mis);
      nvec++;
      if (o_stall !== exp_stall || o_req !== exp_req || o_hung !== 1'b0) begin
        nerr++;
        $display("FAIL rnd%0d_timing: stall %0d req %0d hung %b required %0d %0d 0",
                 n, o_stall, o_req, o_hung, exp_stall, exp_req);
      end
      nvec++;
      if (o_mis !== int'(mis) || o_err !== 0 || o_done !== int'(size != 0 && !mis && !wr)) begin
        nerr++;
        $display("FAIL rnd%0d_pulses: mis %0d err %0d done %0d required %0d 0 %0d",
                 n, o_mis, o_err, o_done, mis, (size != 0 && !mis && !wr));
      end
      if (size != 0 && !mis) begin
        nvec++;
        if (o_addr !== {addr[31:2], 2'b00} || o_we !== wr) begin
          nerr++;
          $display("FAIL rnd%0d_addr: addr %h we %b required %h %b", n, o_addr, o_we,
                   {addr[31:2], 2'b00}, wr);
        end
        nvec++;
        if (wr && {o_be, o_wdata} !== {exp_be, exp_wd}) begin
          nerr++;
          $display("FAIL rnd%0d_store: be %b wdata %h required %b %h", n, o_be, o_wdata, exp_be, exp_wd);
        end else if (!wr && o_ldata !== exp_ld) begin
          nerr++;
          $display("FAIL rnd%0d_load: data %h required %h", n, o_ldata, exp_ld);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dmem_rdata = 32'h0;
    test_reset();
    test_store_lanes();
    test_load_extract();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
